// File: rtl/squeeze_serializer_if.sv
// rtl/squeeze_serializer_if.sv - output word stream bundle of the squeeze serializer
interface squeeze_serializer_if #(
    parameter int W = 64
);
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         dout_last;
    logic [3:0]   dout_bytes;

    modport master (
        output dout,
        output dout_valid,
        output dout_last,
        output dout_bytes,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_valid,
        input  dout_last,
        input  dout_bytes,
        output dout_ready
    );
endinterface

// File: rtl/squeeze_serializer.sv
// rtl/squeeze_serializer.sv - streams squeezed Keccak state lanes, requesting permutations at rate boundaries
module squeeze_serializer #(
    parameter int W              = 64,
    parameter int LEN_WIDTH      = 32,
    parameter int MAX_RATE_WORDS = 21
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] out_len,
    input  logic [4:0]           rate_words,
    output logic [4:0]           state_idx,
    input  logic [W-1:0]         state_word,
    output logic                 perm_start,
    input  logic                 perm_done,
    output logic                 busy,
    output logic                 done,
    squeeze_serializer_if.master dout_if
);
    typedef enum logic [1:0] {IDLE, EMIT, PERM_WAIT, FINISH} state_t;

    localparam logic [LEN_WIDTH-1:0] W_LEN = LEN_WIDTH'(W);
    localparam logic [4:0]           R_MAX = 5'(MAX_RATE_WORDS);
    localparam int                   BW    = $clog2(W + 8) + 1;

    state_t               state;
    state_t               state_nx;
    logic [LEN_WIDTH-1:0] remaining;
    logic [4:0]           rate_q;
    logic [4:0]           rate_eff;
    logic [LEN_WIDTH-1:0] take;
    logic [BW-1:0]        take_small;
    logic [W-1:0]         keep_mask;
    logic                 at_last;
    logic                 at_boundary;

    assign rate_eff    = (rate_words == 5'd0 || rate_words > R_MAX) ? R_MAX : rate_words;
    assign take        = (remaining < W_LEN) ? remaining : W_LEN;
    assign take_small  = BW'(take);
    assign at_last     = (remaining <= W_LEN);
    assign at_boundary = (state_idx == rate_q - 5'd1);

    always_comb begin
        keep_mask = '0;
        for (int i = 0; i < W; i++) begin
            keep_mask[i] = (LEN_WIDTH'(i) < remaining);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (out_len == '0) ? FINISH : EMIT;
                end
            end
            EMIT: begin
                // The last word wins over a coinciding rate boundary: no trailing permutation.
                if (dout_if.dout_ready) begin
                    if (at_last) begin
                        state_nx = FINISH;
                    end else if (at_boundary) begin
                        state_nx = PERM_WAIT;
                    end
                end
            end
            PERM_WAIT: begin
                if (perm_done) begin
                    state_nx = EMIT;
                end
            end
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining  <= '0;
            rate_q     <= '0;
            state_idx  <= '0;
            perm_start <= 1'b0;
        end else begin
            perm_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= out_len;
                        rate_q    <= rate_eff;
                        state_idx <= '0;
                    end
                end
                EMIT: begin
                    if (dout_if.dout_ready) begin
                        remaining <= remaining - take;
                        if (!at_last) begin
                            state_idx  <= at_boundary ? 5'd0 : state_idx + 5'd1;
                            perm_start <= at_boundary;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        dout_if.dout       = '0;
        dout_if.dout_valid = 1'b0;
        dout_if.dout_last  = 1'b0;
        dout_if.dout_bytes = 4'd0;
        busy               = (state != IDLE);
        done               = (state == FINISH);
        if (state == EMIT) begin
            dout_if.dout       = state_word & keep_mask;
            dout_if.dout_valid = 1'b1;
            dout_if.dout_last  = at_last;
            dout_if.dout_bytes = 4'((take_small + BW'(7)) >> 3);
        end
    end
endmodule

// File: tb/tb_squeeze_serializer.sv
// tb/tb_squeeze_serializer.sv - scoreboard bench for squeeze_serializer
module tb_squeeze_serializer;
    localparam int W    = 64;
    localparam int LW   = 32;
    localparam int MAXR = 21;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
        logic [3:0]   bytes;
        logic [4:0]   idx;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [LW-1:0] out_len = '0;
    logic [4:0]    rate_words = '0;
    logic [4:0]    state_idx;
    logic [W-1:0]  state_word;
    logic          perm_start;
    logic          perm_done = 1'b0;
    logic          busy;
    logic          done;

    squeeze_serializer_if #(.W(W)) dif ();

    squeeze_serializer #(.W(W), .LEN_WIDTH(LW), .MAX_RATE_WORDS(MAXR)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .out_len    (out_len),
        .rate_words (rate_words),
        .state_idx  (state_idx),
        .state_word (state_word),
        .perm_start (perm_start),
        .perm_done  (perm_done),
        .busy       (busy),
        .done       (done),
        .dout_if    (dif)
    );

    always #5 clk = ~clk;

    exp_t        exp_q[$];
    exp_t        e_mon;
    int          checks = 0;
    int          errors = 0;
    int unsigned seed = 0;
    int unsigned gen = 0;
    int unsigned perm_cnt = 0;
    int unsigned exp_perms = 0;
    int unsigned pend = 0;
    bit          resp_hold = 1'b0;
    bit          stall_en = 1'b0;
    bit          spur_en = 1'b0;
    bit          prev_stall = 1'b0;
    logic [W-1:0] held_dout;
    logic         held_last;
    logic [3:0]   held_bytes;
    logic [4:0]   held_idx;

    // Lane contents of the state after g permutations of request seed s.
    function automatic logic [63:0] lane_val(int unsigned s, int unsigned g, int unsigned i);
        logic [63:0] a;
        a = {s, s ^ 32'h5a5a1234} ^ (64'(g) * 64'h9E3779B97F4A7C15) ^ (64'(i + 1) * 64'hC2B2AE3D27D4EB4F);
        return a ^ (a >> 29);
    endfunction

    always_comb state_word = lane_val(seed, gen, 32'(state_idx));

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Permutation model: completes 1..5 cycles after perm_start, optionally injects stray perm_done.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            perm_done = 1'b0;
            if (rst) begin
                pend = 0;
            end else if (perm_start) begin
                pend = $urandom_range(1, 5);
            end else if (pend > 0 && !resp_hold) begin
                pend--;
                if (pend == 0) begin
                    gen++;
                    perm_done = 1'b1;
                end
            end else if (spur_en && pend == 0 && dif.dout_valid && $urandom_range(0, 5) == 0) begin
                perm_done = 1'b1;
            end
        end
    end

    initial begin
        dif.dout_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            dif.dout_ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (perm_start) perm_cnt++;
            if (dif.dout_valid) begin
                if (prev_stall) begin
                    chk("stall dout stable", dif.dout, held_dout);
                    chk("stall last stable", 64'(dif.dout_last), 64'(held_last));
                    chk("stall bytes stable", 64'(dif.dout_bytes), 64'(held_bytes));
                    chk("stall idx stable", 64'(state_idx), 64'(held_idx));
                end
                if (dif.dout_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected dout_valid", 64'(dif.dout_valid), 64'd0);
                    end else begin
                        e_mon = exp_q.pop_front();
                        chk("dout", dif.dout, e_mon.data);
                        chk("dout_last", 64'(dif.dout_last), 64'(e_mon.last));
                        chk("dout_bytes", 64'(dif.dout_bytes), 64'(e_mon.bytes));
                        chk("state_idx", 64'(state_idx), 64'(e_mon.idx));
                    end
                end
                prev_stall = !dif.dout_ready;
                held_dout  = dif.dout;
                held_last  = dif.dout_last;
                held_bytes = dif.dout_bytes;
                held_idx   = state_idx;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    task automatic issue(int unsigned len, int unsigned rin);
        int unsigned r;
        int unsigned nw;
        int unsigned rem;
        int unsigned take;
        exp_t        e;
        r = (rin == 0 || rin > MAXR) ? MAXR : rin;
        seed = $urandom;
        gen = 0;
        perm_cnt = 0;
        nw = (len + W - 1) / W;
        exp_perms = (nw == 0) ? 0 : (nw - 1) / r;
        for (int unsigned k = 0; k < nw; k++) begin
            rem = len - k * W;
            take = (rem < W) ? rem : W;
            e.data  = lane_val(seed, k / r, k % r) & ((take >= W) ? {W{1'b1}} : ((64'd1 << take) - 64'd1));
            e.last  = (rem <= W);
            e.bytes = 4'((take + 7) / 8);
            e.idx   = 5'(k % r);
            exp_q.push_back(e);
        end
        start = 1'b1;
        out_len = len;
        rate_words = 5'(rin);
        @(posedge clk);
        #1;
        start = 1'b0;
        out_len = $urandom;
        rate_words = 5'($urandom);
        chk("busy after start", 64'(busy), 64'd1);
    endtask

    task automatic wait_done(string name, output int cycles);
        cycles = 0;
        while (!done && cycles < 5000) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        chk({name, " done seen"}, 64'(done), 64'd1);
        chk({name, " queue drained"}, 64'(exp_q.size()), 64'd0);
        chk({name, " perm_start count"}, 64'(perm_cnt), 64'(exp_perms));
        exp_q.delete();
        @(posedge clk);
        #1;
        chk({name, " done one cycle"}, 64'(done), 64'd0);
        chk({name, " idle after done"}, 64'(busy), 64'd0);
    endtask

    task automatic chk_reset_outputs(string name);
        chk({name, " state_idx"}, 64'(state_idx), 64'd0);
        chk({name, " dout"}, dif.dout, 64'd0);
        chk({name, " dout_valid"}, 64'(dif.dout_valid), 64'd0);
        chk({name, " dout_last"}, 64'(dif.dout_last), 64'd0);
        chk({name, " dout_bytes"}, 64'(dif.dout_bytes), 64'd0);
        chk({name, " perm_start"}, 64'(perm_start), 64'd0);
        chk({name, " busy"}, 64'(busy), 64'd0);
        chk({name, " done"}, 64'(done), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        int k;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;

        issue(256, 21);
        wait_done("len256", cyc);
        chk("len256 latency", 64'(cyc), 64'd4);

        issue(1344 * 2, 21);
        wait_done("len2688", cyc);

        issue(100, 17);
        wait_done("len100", cyc);

        issue(0, 21);
        wait_done("len0", cyc);
        chk("len0 latency", 64'(cyc), 64'd0);

        stall_en = 1'b1;
        spur_en = 1'b1;
        issue(1344 * 2 + 100, 17);
        wait_done("stall", cyc);

        for (int i = 0; i < 12; i++) begin
            stall_en = ($urandom_range(0, 1) == 1);
            issue($urandom_range(0, 3000), $urandom_range(0, 31));
            wait_done("random", cyc);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        stall_en = 1'b0;
        spur_en = 1'b0;

        resp_hold = 1'b1;
        issue(2000, 21);
        k = 0;
        while (!perm_start && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("perm_start before reset", 64'(perm_start), 64'd1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_reset_outputs("async reset");
        exp_q.delete();
        @(posedge clk);
        #1;
        chk_reset_outputs("held reset");
        rst = 1'b0;
        resp_hold = 1'b0;
        issue(64, 21);
        wait_done("post reset", cyc);
        chk("post reset latency", 64'(cyc), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
